// File: rtl/line_buffer_fifo.sv
// Line buffer with two behaviours: a normal FIFO (mode=0) and a fixed-length
// delay line (mode=1) that pops its oldest word whenever a write lands while full.
module line_buffer_fifo #(
    parameter int DATA_W   = 1,
    parameter int DEPTH    = 14,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              mode,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic wr_req;
    logic rd_req;
    logic rd_acc;
    logic do_wr;
    logic do_rd;
    logic ovf_set;
    logic udf_set;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(AF_LEVEL));

    // In delay-line mode a write while full is a simultaneous push and pop;
    // rd is ignored entirely, so a delay-line write can never be rejected.
    always_comb begin
        wr_req  = en & wr;
        rd_req  = en & rd & ~mode;
        rd_acc  = rd_req & ~empty;
        do_rd   = mode ? (wr_req & full) : rd_acc;
        do_wr   = mode ? wr_req : (wr_req & (~full | rd_acc));
        ovf_set = ~mode & wr_req & ~do_wr;
        udf_set = rd_req & empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr   <= bump(rd_ptr);
                data_out <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= overflow | ovf_set;
            underflow <= underflow | udf_set;
        end
    end

    // Storage is deliberately left out of reset; reading it before a write is
    // prevented by count, not by its contents.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_line_buffer_fifo.sv
// Directed bench for line_buffer_fifo: a vector table for the main 14-deep
// instance plus hand sequences for async reset and pointer wrap at depth 5.
module tb_line_buffer_fifo;

    typedef struct {
        logic       en, clr, mode, wr, rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       ov;
        logic [3:0] cnt;
        logic       ovf, udf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1, clr = 1'b0, mode = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       ov, emp, ful, af, ovf, udf;
    logic [3:0] cnt;

    logic       wr5 = 1'b0, rd5 = 1'b0;
    logic [7:0] din5 = '0;
    logic [7:0] dout5;
    logic       ov5, emp5, ful5, af5, ovf5, udf5;
    logic [2:0] cnt5;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    line_buffer_fifo #(.DATA_W(8), .DEPTH(14), .AF_LEVEL(12)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .wr(wr), .rd(rd),
        .data_in(din), .data_out(dout), .out_valid(ov), .empty(emp), .full(ful),
        .almost_full(af), .count(cnt), .overflow(ovf), .underflow(udf)
    );

    line_buffer_fifo #(.DATA_W(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .wr(wr5), .rd(rd5),
        .data_in(din5), .data_out(dout5), .out_valid(ov5), .empty(emp5), .full(ful5),
        .almost_full(af5), .count(cnt5), .overflow(ovf5), .underflow(udf5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, c, m, w, r, input logic [7:0] di,
                       input logic [7:0] dq, input logic v, input int n,
                       input logic of, uf);
        vec_t x;
        x.en = e; x.clr = c; x.mode = m; x.wr = w; x.rd = r; x.din = di;
        x.dout = dq; x.ov = v; x.cnt = 4'(n); x.ovf = of; x.udf = uf;
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic [7:0] dq, input logic v,
                            input logic [3:0] n, input logic of, uf);
        chk({tag, " data_out"}, 32'(dout), 32'(dq));
        chk({tag, " out_valid"}, 32'(ov), 32'(v));
        chk({tag, " count"}, 32'(cnt), 32'(n));
        chk({tag, " empty"}, 32'(emp), 32'(n == 0));
        chk({tag, " full"}, 32'(ful), 32'(n == 14));
        chk({tag, " almost_full"}, 32'(af), 32'(n >= 12));
        chk({tag, " overflow"}, 32'(ovf), 32'(of));
        chk({tag, " underflow"}, 32'(udf), 32'(uf));
    endtask

    initial begin
        // fill then drain
        for (int i = 1; i <= 14; i++) add(1, 0, 0, 1, 0, 8'(i), 8'h00, 0, i, 0, 0);
        for (int i = 1; i <= 14; i++) add(1, 0, 0, 0, 1, 8'h00, 8'(i), 1, 14 - i, 0, 0);
        for (int i = 1; i <= 14; i++) add(1, 0, 0, 1, 0, 8'(i), 8'h0E, 0, i, 0, 0);
        // full: rd+wr both accepted, then a lone write is dropped
        add(1, 0, 0, 1, 1, 8'h55, 8'h01, 1, 14, 0, 0);
        add(1, 0, 0, 1, 0, 8'h66, 8'h01, 0, 14, 1, 0);
        add(1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 14, 1, 0);
        add(1, 1, 0, 1, 1, 8'h77, 8'h01, 0, 0, 0, 0);
        // empty: rd+wr -> write only, underflow
        add(1, 0, 0, 1, 1, 8'hAA, 8'h01, 0, 1, 0, 1);
        add(1, 0, 0, 0, 1, 8'h00, 8'hAA, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 8'h00, 8'hAA, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 8'h00, 8'hAA, 0, 0, 0, 0);
        // clock enable
        add(1, 0, 0, 1, 0, 8'h10, 8'hAA, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 8'h11, 8'hAA, 0, 2, 0, 0);
        add(1, 0, 0, 1, 0, 8'h12, 8'hAA, 0, 3, 0, 0);
        add(0, 0, 0, 1, 1, 8'h99, 8'hAA, 0, 3, 0, 0);
        add(0, 0, 0, 1, 0, 8'h98, 8'hAA, 0, 3, 0, 0);
        add(0, 0, 0, 0, 1, 8'h00, 8'hAA, 0, 3, 0, 0);
        add(1, 0, 0, 0, 1, 8'h00, 8'h10, 1, 2, 0, 0);
        add(0, 1, 0, 1, 1, 8'h97, 8'h10, 0, 0, 0, 0);
        // mode switch keeps contents, rd ignored in delay-line mode
        add(1, 0, 0, 1, 0, 8'h20, 8'h10, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 8'h21, 8'h10, 0, 2, 0, 0);
        add(1, 0, 1, 0, 0, 8'h00, 8'h10, 0, 2, 0, 0);
        add(1, 0, 1, 0, 1, 8'h00, 8'h10, 0, 2, 0, 0);
        add(1, 0, 0, 0, 1, 8'h00, 8'h20, 1, 1, 0, 0);
        add(1, 1, 0, 0, 0, 8'h00, 8'h20, 0, 0, 0, 0);
        // delay line: output first on the 15th write, 14 writes late
        for (int k = 0; k < 30; k++)
            add(1, 0, 1, 1, 0, 8'(k), (k >= 14) ? 8'(k - 14) : 8'h20,
                k >= 14, (k + 1 < 14) ? k + 1 : 14, 0, 0);
        add(1, 0, 1, 0, 0, 8'h00, 8'd15, 0, 14, 0, 0);
        add(1, 0, 0, 0, 1, 8'h00, 8'd16, 1, 13, 0, 0);

        #2;
        chk_main("reset_held", 8'h00, 0, 0, 0, 0);
        chk("reset_held dut5 count", 32'(cnt5), 32'd0);
        #20 rst = 1'b1;
        chk_main("reset_release", 8'h00, 0, 0, 0, 0);
        step();

        foreach (vecs[i]) begin
            en = vecs[i].en; clr = vecs[i].clr; mode = vecs[i].mode;
            wr = vecs[i].wr; rd = vecs[i].rd; din = vecs[i].din;
            step();
            chk_main($sformatf("vec%0d", i), vecs[i].dout, vecs[i].ov, vecs[i].cnt,
                     vecs[i].ovf, vecs[i].udf);
        end

        // async reset mid-burst, with data_out nonzero beforehand
        en = 1'b1; clr = 1'b0; mode = 1'b0; rd = 1'b0; wr = 1'b1; din = 8'h33;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_main("async_reset", 8'h00, 0, 0, 0, 0);
        wr = 1'b0;
        #2 rst = 1'b1;
        step();
        rd = 1'b1;
        step();
        chk_main("post_reset_read", 8'h00, 0, 0, 0, 1);
        rd = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;

        // depth-5 wrap: keep 3 words resident while 37 rd+wr pairs stream through
        for (int i = 0; i < 3; i++) begin
            wr5 = 1'b1; din5 = 8'(100 + i);
            step();
        end
        chk("wrap prefill count", 32'(cnt5), 32'd3);
        for (int j = 0; j < 37; j++) begin
            wr5 = 1'b1; rd5 = 1'b1; din5 = 8'(103 + j);
            step();
            chk($sformatf("wrap%0d data_out", j), 32'(dout5), 32'(100 + j));
            chk($sformatf("wrap%0d out_valid", j), 32'(ov5), 32'd1);
            chk($sformatf("wrap%0d count", j), 32'(cnt5), 32'd3);
            chk($sformatf("wrap%0d flags", j), 32'({emp5, ful5}), 32'd0);
        end
        wr5 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            rd5 = 1'b1;
            step();
            chk($sformatf("drain%0d data_out", j), 32'(dout5), 32'(137 + j));
        end
        rd5 = 1'b0;
        step();
        chk("wrap final empty", 32'(emp5), 32'd1);
        chk("wrap final out_valid", 32'(ov5), 32'd0);
        chk("wrap sticky flags", 32'({ovf5, udf5}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_fifo.md
LINE_BUFFER_FIFO -- requirements
Module: line_buffer_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 1, word width in bits (legal range >= 1).
REQ-002 SHALL have parameter DEPTH, default 14, storage depth in words (>= 2; need not be a power of 2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold in words (1..DEPTH).
REQ-004 SHALL have parameter CNT_W, default $clog2(DEPTH+1), width of count.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: clock enable; when 0, no storage, pointer, count or flag change.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear, honoured regardless of en.
REQ-009 SHALL have port mode, input, 1 bit: 0 = FIFO mode, 1 = delay-line mode.
REQ-010 SHALL have port wr, input, 1 bit: write request.
REQ-011 SHALL have port rd, input, 1 bit: read request (FIFO mode only).
REQ-012 SHALL have port data_in, input, DATA_W bits: write data.
REQ-013 SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-014 SHALL have port out_valid, output, 1 bit: data_out updated this cycle.
REQ-015 SHALL have ports empty, full and almost_full, output, 1 bit each: count==0, count==DEPTH and count>=AF_LEVEL respectively (combinational from count).
REQ-016 SHALL have port count, output, CNT_W bits: words currently stored (0..DEPTH).
REQ-017 SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-018 Read and write pointers SHALL each wrap from DEPTH-1 to 0.
REQ-019 count SHALL be maintained as an explicit register (+1 on write only, -1 on read only, unchanged on both or neither), never derived from pointer difference.
REQ-020 FIFO mode, accepted write: wr=1, en=1, and either not full or a read accepted in the same cycle; the word is stored at the write pointer and the pointer advances.
REQ-021 FIFO mode, accepted read: rd=1, en=1, count!=0; the oldest word appears on data_out at the next edge with out_valid=1 (latency 1 cycle) and the read pointer advances.
REQ-022 FIFO mode, simultaneous rd and wr when full: both SHALL be accepted; count stays DEPTH.
REQ-023 FIFO mode, simultaneous rd and wr when empty: the write SHALL be accepted and the read rejected (no fall-through); count becomes 1 and underflow is set.
REQ-024 FIFO mode, rejected write (wr while full, no accepted read): data SHALL be dropped and overflow set.
REQ-025 Rejected read (rd while empty): underflow SHALL be set, data_out held, out_valid=0.
REQ-026 Delay-line mode: rd SHALL be ignored; a write with count<DEPTH only pushes; a write with count==DEPTH pushes and pops the oldest word in the same cycle (data_out=oldest, out_valid=1 next cycle, count stays DEPTH); overflow is never set.
REQ-027 mode SHALL be sampled every cycle; a mode change SHALL retain contents, pointers and count.
REQ-028 out_valid SHALL be 0 in any cycle without an accepted read/pop, including while en=0; data_out SHALL hold its last value.
REQ-029 overflow and underflow SHALL remain set until clr or reset.
REQ-030 clr=1 SHALL zero both pointers, count, out_valid, overflow and underflow at the next edge with priority over wr/rd; data_out and storage contents are unchanged.

Reset
REQ-031 rst=0 SHALL immediately zero both pointers, count, data_out, out_valid, overflow and underflow, independent of clk and en; storage array is not reset.
REQ-032 After rst deasserts: empty=1, full=0, almost_full=0 (for AF_LEVEL>=1), count=0.
REQ-033 Reset asserted mid-transfer SHALL discard all stored words; the first post-reset read is an underflow.

Verification (DATA_W=8, DEPTH=14, AF_LEVEL=12 unless noted)
REQ-034 Reset, then write 0x01..0x0E in FIFO mode -> count=14, full=1, almost_full asserted from count=12; read 14 times -> data_out 0x01..0x0E, each 1 cycle after rd, empty=1 at end.
REQ-035 Full, then rd+wr 0x55 same cycle -> data_out=0x01, count stays 14, overflow=0; further wr alone -> dropped, overflow=1 until clr.
REQ-036 Empty, rd+wr 0xAA -> count=1, out_valid=0, underflow=1; next rd -> data_out=0xAA.
REQ-037 Delay-line mode, write 0..29 continuously -> out_valid first at the 15th write, data_out[n] = value written 14 writes earlier; count holds 14.
REQ-038 Pointer wrap with DEPTH=5 and 37 interleaved write/read pairs -> strict order preserved, no spurious full/empty.
REQ-039 en=0 with wr/rd toggling -> no state change; rst pulsed low mid-burst -> all outputs zero asynchronously, empty=1.
